// File: rtl/seq_cmp_pkg.sv
// Shared types and default geometry for the sequential magnitude comparator.
package seq_cmp_pkg;

    localparam int unsigned DefWidth = 16;
    localparam int unsigned DefDigit = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mag_cmp_if.sv
// Request/result bundle for seq_mag_cmp.
// SEQ_CMP_SIGNED_EN adds the signed_mode request bit.
interface seq_mag_cmp_if
    import seq_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) ();

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             eq_in;
    logic             gt_in;
`ifdef SEQ_CMP_SIGNED_EN
    logic             signed_mode;
`endif
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output start, a, b, eq_in, gt_in,
`ifdef SEQ_CMP_SIGNED_EN
        output signed_mode,
`endif
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, a, b, eq_in, gt_in,
`ifdef SEQ_CMP_SIGNED_EN
        input  signed_mode,
`endif
        output busy, done, eq, gt, lt
    );

endinterface

// File: rtl/cmp_digit.sv
// Combinational DIGIT-bit unsigned slice comparator.
module cmp_digit #(
    parameter int unsigned DIGIT = 2
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             eq_o,
    output logic             gt_o
);

    assign eq_o = (a_i == b_i);
    assign gt_o = (a_i > b_i);

endmodule

// File: rtl/seq_mag_cmp.sv
// Sequential magnitude comparator: walks the operands DIGIT bits per clock, MSB first,
// exiting early on the first differing digit. A cascade eq_in=0 skips the walk entirely.
// SEQ_CMP_SIGNED_EN adds two's-complement ordering via signed_mode.
module seq_mag_cmp
    import seq_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DIGIT = DefDigit
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_mag_cmp_if.slave bus
);

    localparam bit          CfgOk   = (DIGIT >= 1) && ((WIDTH % ((DIGIT >= 1) ? DIGIT : 1)) == 0);
    localparam int unsigned N       = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
    localparam int unsigned CntW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    if (!CfgOk) begin : g_bad_cfg
        $error("seq_mag_cmp: WIDTH must be a non-zero multiple of DIGIT");
    end

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              eq_q, eq_d, gt_q, gt_d, lt_q, lt_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0]  msb_flip;
    logic [DIGIT-1:0]  a_dig, b_dig;
    logic              dig_eq, dig_gt;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        msb_flip = '0;
`ifdef SEQ_CMP_SIGNED_EN
        msb_flip[WIDTH-1] = bus.signed_mode;
`endif
    end

    // Select the digit addressed by the counter, MSB digit first.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (cnt_q == CntW'(i)) begin
                a_dig = a_q[WIDTH-1-i*DIGIT -: DIGIT];
                b_dig = b_q[WIDTH-1-i*DIGIT -: DIGIT];
            end
        end
    end

    cmp_digit #(
        .DIGIT (DIGIT)
    ) u_cmp_digit (
        .a_i  (a_dig),
        .b_i  (b_dig),
        .eq_o (dig_eq),
        .gt_o (dig_gt)
    );

    // Next-state, operand latch and result update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d   = bus.a ^ msb_flip;
                    b_d   = bus.b ^ msb_flip;
                    cnt_d = '0;
                    if (bus.eq_in) begin
                        state_d = StRun;
                    end else begin
                        // Higher slices already decided the outcome.
                        state_d = StDone;
                        done_d  = 1'b1;
                        eq_d    = 1'b0;
                        gt_d    = bus.gt_in;
                        lt_d    = ~bus.gt_in;
                    end
                end
            end
            StRun: begin
                if (!dig_eq) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    eq_d    = 1'b0;
                    gt_d    = dig_gt;
                    lt_d    = ~dig_gt;
                end else if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.eq   = eq_q;
    assign bus.gt   = gt_q;
    assign bus.lt   = lt_q;

endmodule
